// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the alu_seq_ctrl instruction sequencer.
// Contents:
//   state_t             sequencer FSM states
//   OP_*                opcodes the sequencer treats specially
//   *_MSB / *_LSB       bit positions of the 16-bit instruction fields
//   updates_carry()     opcodes whose ALU carry becomes the architectural carry
//   is_div_op()         opcodes that divide by reg[rb]
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_MOD  = 4'b0100;

  // Instruction layout: [15:12] opcode, [11:10] rd, [9:8] ra, [7:6] rb,
  // [5:0] reserved.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RA_MSB  = 9;
  localparam int RA_LSB  = 8;
  localparam int RB_MSB  = 7;
  localparam int RB_LSB  = 6;

  function automatic logic updates_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile
// 4x8 register file: one synchronous write port, three combinational reads.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (clears all)
//   we, waddr, wdata      write port
//   ra_addr / ra_data     operand A read
//   rb_addr / rb_data     operand B read
//   dbg_addr / dbg_data   debug read
module alu_seq_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] ra_addr,
  input  logic [1:0] rb_addr,
  input  logic [1:0] dbg_addr,
  output logic [7:0] ra_data,
  output logic [7:0] rb_data,
  output logic [7:0] dbg_data
);

  logic [7:0] regs [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
// Instruction sequencer for the 8-bit alu. Fetches 16-bit instructions from
// a synchronous instruction memory, reads operands from a 4x8 register file,
// pulses alu_enable once per instruction and writes result and flags back.
// Optional feature macro: ALU_SEQ_DIV_GUARD_EN (divide/modulo-by-zero guard;
// when undefined err is tied to 0).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       run program from address 0 (IDLE only)
//   imem_addr / imem_data       instruction memory (data one cycle after addr)
//   host_we/waddr/wdata         host register write (IDLE only, start wins)
//   dbg_raddr / dbg_rdata       combinational debug register read
//   alu_a, alu_b, alu_opcode    ALU operands and opcode
//   alu_enable                  one-cycle ALU strobe (EXEC)
//   alu_op, alu_carry, alu_zero ALU result and flags (sampled in WB)
//   busy, done, err             status: not IDLE, end pulse, sticky error
//   flag_c, flag_z, pc          architectural flags and program counter
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            host_we,
  input  logic [1:0]      host_waddr,
  input  logic [7:0]      host_wdata,
  input  logic [1:0]      dbg_raddr,
  output logic [7:0]      dbg_rdata,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [3:0]      alu_opcode,
  output logic            alu_enable,
  input  logic [7:0]      alu_op,
  input  logic            alu_carry,
  input  logic            alu_zero,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            flag_c,
  output logic            flag_z,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] PC_LAST = '1;

  state_t      state, state_next;
  logic [15:0] instr_q;
  logic [3:0]  dec_op;
  logic [7:0]  ra_data, rb_data;
  logic        rf_we;
  logic [1:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic        div_zero;
  logic        pc_at_end;
  logic        unused_instr;

  // The memory registers the address at the end of FETCH, so imem_data is
  // decoded straight off the bus in DECODE.
  assign dec_op       = imem_data[OPC_MSB:OPC_LSB];
  assign pc_at_end    = (pc == PC_LAST);
  assign imem_addr    = pc;
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign unused_instr = ^instr_q[RA_MSB:0];

`ifdef ALU_SEQ_DIV_GUARD_EN
  assign div_zero = is_div_op(dec_op) && (rb_data == 8'd0);
`else
  assign div_zero = 1'b0;
`endif

  alu_seq_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .ra_addr  (imem_data[RA_MSB:RA_LSB]),
    .rb_addr  (imem_data[RB_MSB:RB_LSB]),
    .dbg_addr (dbg_raddr),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (dbg_rdata)
  );

  // Single write port: writeback in WB, host writes only while idle and only
  // when start is not asserted in the same cycle.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = instr_q[RD_MSB:RD_LSB];
    rf_wdata = alu_op;
    if (state == S_WB) begin
      rf_we = 1'b1;
    end else if ((state == S_IDLE) && host_we && !start) begin
      rf_we    = 1'b1;
      rf_waddr = host_waddr;
      rf_wdata = host_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // A guarded divide skips EXEC/WB and advances pc straight from DECODE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (dec_op == OP_HALT) state_next = S_DONE;
        else if (div_zero)     state_next = pc_at_end ? S_DONE : S_FETCH;
        else                   state_next = S_EXEC;
      end
      S_EXEC:   state_next = S_WB;
      S_WB:     state_next = pc_at_end ? S_DONE : S_FETCH;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // alu_enable is registered from the next state so it is high exactly in
  // EXEC, and the async reset drops it immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      instr_q    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      alu_enable <= 1'b0;
      flag_c     <= 1'b0;
      flag_z     <= 1'b0;
    end else begin
      alu_enable <= (state_next == S_EXEC);
      case (state)
        S_IDLE: begin
          if (start) begin
            pc     <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
          end
        end
        S_DECODE: begin
          instr_q <= imem_data;
          if ((dec_op != OP_HALT) && !div_zero) begin
            alu_a      <= ra_data;
            alu_b      <= rb_data;
            alu_opcode <= dec_op;
          end else if (div_zero && !pc_at_end) begin
            pc <= pc + 1'b1;
          end
        end
        S_WB: begin
          flag_z <= alu_zero;
          if (updates_carry(instr_q[OPC_MSB:OPC_LSB])) flag_c <= alu_carry;
          if (!pc_at_end) pc <= pc + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_DIV_GUARD_EN
  // Sticky until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               err <= 1'b0;
    else if ((state == S_IDLE) && start)      err <= 1'b0;
    else if ((state == S_DECODE) && div_zero) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
// Bench for alu_seq_ctrl (default build). Provides a behavioural ALU and a
// synchronous instruction memory; a second instance with PC_W=2 covers the
// program-counter wrap.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start, start2;
  logic        host_we;
  logic [1:0]  host_waddr;
  logic [7:0]  host_wdata;
  logic [1:0]  dbg_raddr;

  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [7:0]  dbg_rdata, alu_a, alu_b, alu_op;
  logic [3:0]  alu_opcode;
  logic        alu_enable, alu_carry, alu_zero;
  logic        busy, done, err, flag_c, flag_z;
  logic [7:0]  pc;

  logic [1:0]  imem_addr2, pc2;
  logic [15:0] imem_data2;
  logic [7:0]  dbg_rdata2, alu_a2, alu_b2, alu_op2;
  logic [3:0]  alu_opcode2;
  logic        alu_enable2, alu_carry2, alu_zero2;
  logic        busy2, done2, err2, flag_c2, flag_z2;

  logic [15:0] imem  [256];
  logic [15:0] imem2 [4];
  logic [8:0]  alu_res, alu_res2;

  typedef struct {
    logic [1:0] rd;
    logic [7:0] val;
    logic       c;
    logic       z;
  } wb_t;

  typedef struct {
    logic [7:0]  r0, r1, r2, r3;
    logic [15:0] instr;
    logic [1:0]  rd;
    logic [7:0]  val;
    logic        c;
    logic        z;
  } vec_t;

  wb_t        sbq[$];
  logic [7:0] en_addrs[$];
  vec_t       vecs[10];
  int         total = 0;
  int         bad = 0;

  alu_seq_ctrl #(.PC_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_enable(alu_enable),
    .alu_op(alu_op), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .busy(busy), .done(done), .err(err), .flag_c(flag_c), .flag_z(flag_z), .pc(pc)
  );

  alu_seq_ctrl #(.PC_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .imem_addr(imem_addr2), .imem_data(imem_data2),
    .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata2),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_opcode(alu_opcode2), .alu_enable(alu_enable2),
    .alu_op(alu_op2), .alu_carry(alu_carry2), .alu_zero(alu_zero2),
    .busy(busy2), .done(done2), .err(err2), .flag_c(flag_c2), .flag_z(flag_z2), .pc(pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: {carry, result}. Logic ops report carry=1 so that a
  // carry update on a non-ADD/SUB instruction is visible.
  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd1:    return {1'b0, a} + {1'b0, b};
      4'd2:    return {(a < b), a - b};
      4'd3:    return (b == 8'd0) ? {1'b0, 8'hFF} : {1'b0, a / b};
      4'd4:    return (b == 8'd0) ? {1'b0, a} : {1'b0, a % b};
      4'd5:    return {1'b1, a & b};
      4'd6:    return {1'b1, a | b};
      4'd7:    return {1'b1, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    imem_data  <= imem[imem_addr];
    imem_data2 <= imem2[imem_addr2];
  end

  always @(posedge clk) begin
    if (alu_enable) begin
      alu_res   = alu_fn(alu_opcode, alu_a, alu_b);
      alu_op    <= alu_res[7:0];
      alu_carry <= alu_res[8];
      alu_zero  <= (alu_res[7:0] == 8'd0);
    end
    if (alu_enable2) begin
      alu_res2   = alu_fn(alu_opcode2, alu_a2, alu_b2);
      alu_op2    <= alu_res2[7:0];
      alu_carry2 <= alu_res2[8];
      alu_zero2  <= (alu_res2[7:0] == 8'd0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2, input logic [7:0] v3);
    logic [7:0] v[4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      host_we    = 1'b1;
      host_waddr = 2'(i);
      host_wdata = v[i];
    end
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic check_wb();
    wb_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL wb_unexpected actual=writeback required=none");
    end else begin
      e = sbq.pop_front();
      dbg_raddr = e.rd;
      #1;
      checkOutput("wb_reg", dbg_rdata, e.val);
      checkOutput("wb_flag_c", flag_c, e.c);
      checkOutput("wb_flag_z", flag_z, e.z);
    end
  endtask

  // Start the primary DUT and follow it to done, checking each writeback
  // from the scoreboard two cycles after its enable pulse.
  task automatic run_prog(input int exp_en, input int budget);
    int cyc = 0;
    int en_cnt = 0;
    int done_cnt = 0;
    int last_en = -1;
    int wb_at = -1;
    bit fin = 0;
    en_addrs.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cyc == wb_at) check_wb();
      if (alu_enable) begin
        en_cnt++;
        if (last_en < 0) checkOutput("first_enable_cycle", cyc, 3);
        else             checkOutput("enable_spacing", cyc - last_en, 4);
        last_en = cyc;
        en_addrs.push_back(imem_addr);
        wb_at = cyc + 2;
      end
      if (done) begin
        done_cnt++;
        fin = 1;
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout actual=no done required=done within %0d cycles", budget);
    end
    @(negedge clk);
    if (done) done_cnt++;
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("enable_pulses", en_cnt, exp_en);
    checkOutput("busy_after", busy, 0);
    checkOutput("err_after", err, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  cyc;
    int  en2;
    int  done_cyc;
    bit  found;

    vecs[0] = '{8'hF0, 8'h20, 8'h00, 8'h00, 16'h1840, 2'd2, 8'h10, 1'b1, 1'b0};
    vecs[1] = '{8'h55, 8'h55, 8'h00, 8'h00, 16'h2C40, 2'd3, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 8'h10, 8'h20, 16'h26C0, 2'd1, 8'hF0, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'h0F, 8'h3C, 8'h00, 16'h5180, 2'd0, 8'h0C, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'hAA, 8'h00, 8'h00, 16'h7540, 2'd1, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{8'h64, 8'h00, 8'h00, 8'h00, 16'h38C0, 2'd2, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h18, 8'h00, 8'h81, 8'h00, 16'h6E3F, 2'd3, 8'h99, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 8'h00, 8'h80, 16'h13C0, 2'd0, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{8'hC8, 8'h00, 8'h07, 8'h00, 16'h3480, 2'd1, 8'h1C, 1'b0, 1'b0};
    vecs[9] = '{8'hC8, 8'h07, 8'h00, 8'h00, 16'h4C40, 2'd3, 8'h04, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    host_we = 1'b0; host_waddr = '0; host_wdata = '0; dbg_raddr = '0;
    clear_imem();
    for (int i = 0; i < 4; i++) imem2[i] = 16'h1500;

    // Reset values
    #7;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_alu_enable", alu_enable, 0);
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_imem_addr", imem_addr, 0);
    checkOutput("rst_flags", {flag_c, flag_z}, 0);
    checkOutput("rst_alu_operands", {alu_a, alu_b, alu_opcode}, 0);
    for (int i = 0; i < 4; i++) begin
      dbg_raddr = 2'(i);
      #1 checkOutput("rst_reg", dbg_rdata, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Single-instruction vectors followed by HALT
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].r0, vecs[v].r1, vecs[v].r2, vecs[v].r3);
      clear_imem();
      imem[0] = vecs[v].instr;
      sbq.push_back('{vecs[v].rd, vecs[v].val, vecs[v].c, vecs[v].z});
      run_prog(1, 40);
    end

    // Zero flag set by SUB, carry held across AND
    applyStimulus(8'h55, 8'h55, 8'h00, 8'h00);
    clear_imem();
    imem[0] = 16'h2C40;
    imem[1] = 16'h5840;
    sbq.push_back('{2'd3, 8'h00, 1'b0, 1'b1});
    sbq.push_back('{2'd2, 8'h55, 1'b0, 1'b0});
    run_prog(2, 60);

    // Back-to-back sequence: enables 4 cycles apart, addresses 0,1,2, HALT at 3
    applyStimulus(8'h01, 8'h02, 8'h00, 8'h00);
    clear_imem();
    for (int i = 0; i < 3; i++) imem[i] = 16'h1040;
    sbq.push_back('{2'd0, 8'h03, 1'b0, 1'b0});
    sbq.push_back('{2'd0, 8'h05, 1'b0, 1'b0});
    sbq.push_back('{2'd0, 8'h07, 1'b0, 1'b0});
    run_prog(3, 80);
    checkOutput("seq_enable_count", en_addrs.size(), 3);
    for (int i = 0; i < en_addrs.size() && i < 3; i++) checkOutput("seq_imem_addr", en_addrs[i], i);
    checkOutput("seq_pc_at_halt", pc, 3);

    // PC wrap on the PC_W=2 instance: four ADD r1,r1,r0 then done at address 3
    applyStimulus(8'h01, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    en2 = 0;
    done_cyc = -1;
    cyc = 0;
    while (done_cyc < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (alu_enable2) en2++;
      if (done2) done_cyc = cyc;
    end
    checkOutput("wrap_done_cycle", done_cyc, 17);
    checkOutput("wrap_enables", en2, 4);
    checkOutput("wrap_pc", pc2, 3);
    dbg_raddr = 2'd1;
    #1 checkOutput("wrap_r1", dbg_rdata2, 8'h04);
    checkOutput("wrap_flags", {flag_c2, flag_z2, err2}, 0);
    @(negedge clk);
    checkOutput("wrap_done_single", done2, 0);
    checkOutput("wrap_idle", busy2, 0);

    // Reset asserted during EXEC
    applyStimulus(8'h01, 8'h02, 8'h00, 8'h00);
    clear_imem();
    imem[0] = 16'h1840;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (alu_enable) found = 1;
    end
    checkOutput("rstexec_reached", found, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstexec_alu_enable", alu_enable, 0);
    checkOutput("rstexec_busy", busy, 0);
    checkOutput("rstexec_pc", pc, 0);
    dbg_raddr = 2'd2;
    #1 checkOutput("rstexec_rd", dbg_rdata, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstexec_rd_after_edge", dbg_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    checkOutput("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
